// File: rtl/lfsr_period_checker.sv
// ---------------------------------------------------------------------------
// lfsr_period_checker
//
// Streaming monitor for the output of the `lfsr` block. After `start` it
// captures the next valid sample as a reference, counts valid samples until
// that value recurs and reports the measured period, flagging whether it is
// maximal (2^WIDTH - 1). An all-zero sample (lockup) or 2^WIDTH samples
// without recurrence (no_repeat) end the measurement as a failure.
//
// Optional feature, enabled by defining LFSR_CHK_PREDICT_EN:
//   every counted sample is compared with the predicted next LFSR state;
//   a difference sets the sticky `mismatch` flag and the first one records
//   its sample index in `err_index`. Without the macro both outputs are 0.
//
// Parameters:
//   WIDTH     LFSR state width
//   TAPS      feedback mask; feedback bit = ^(state & TAPS)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   one-cycle pulse, arms a new measurement
//   in_valid   in   lfsr_in carries a new sample this cycle
//   lfsr_in    in   LFSR state sample [WIDTH-1:0]
//   busy       out  measurement in progress
//   done       out  reference value recurred (level)
//   maximal    out  done and period == 2^WIDTH - 1
//   period     out  samples from reference to recurrence [WIDTH:0]
//   mismatch   out  sticky, sample differed from predicted next state
//   lockup     out  sticky, all-zero sample received
//   no_repeat  out  sticky, 2^WIDTH samples without recurrence
//   err_index  out  sample index of the first mismatch [WIDTH:0]
// ---------------------------------------------------------------------------
module lfsr_period_checker #(
    parameter int unsigned           WIDTH = 16,
    parameter logic [WIDTH-1:0]      TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] lfsr_in,
    output logic             busy,
    output logic             done,
    output logic             maximal,
    output logic [WIDTH:0]   period,
    output logic             mismatch,
    output logic             lockup,
    output logic             no_repeat,
    output logic [WIDTH:0]   err_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COUNT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [WIDTH:0] PERIOD_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] TIMEOUT    = {1'b1, {WIDTH{1'b0}}};

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH:0]   cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             maximal_q;
    logic [WIDTH:0]   period_q;
    logic             lockup_q;
    logic             no_repeat_q;

    logic [WIDTH:0]   cnt_inc;
    logic             sample_zero;

    assign cnt_inc     = cnt_q + 1'b1;
    assign sample_zero = (lfsr_in == '0);

`ifdef LFSR_CHK_PREDICT_EN
    logic [WIDTH-1:0] pred_q;
    logic             mismatch_q;
    logic [WIDTH:0]   err_index_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_q      <= '0;
            mismatch_q  <= 1'b0;
            err_index_q <= '0;
        end else if (start) begin
            mismatch_q  <= 1'b0;
            err_index_q <= '0;
        end else if (in_valid && state_q == S_ARMED) begin
            pred_q <= lfsr_next(lfsr_in);
        end else if (in_valid && state_q == S_COUNT) begin
            // Resynchronise to the actual stream so one corrupt sample
            // does not cascade into a mismatch on every later sample.
            pred_q <= lfsr_next(lfsr_in);
            if (lfsr_in != pred_q) begin
                mismatch_q <= 1'b1;
                if (!mismatch_q) begin
                    err_index_q <= cnt_inc;
                end
            end
        end
    end

    assign mismatch  = mismatch_q;
    assign err_index = err_index_q;
`else
    assign mismatch  = 1'b0;
    assign err_index = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ref_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            maximal_q   <= 1'b0;
            period_q    <= '0;
            lockup_q    <= 1'b0;
            no_repeat_q <= 1'b0;
        end else if (start) begin
            // Restart from any state; a sample in this cycle is dropped.
            state_q     <= S_ARMED;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            maximal_q   <= 1'b0;
            period_q    <= '0;
            lockup_q    <= 1'b0;
            no_repeat_q <= 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (in_valid) begin
                        ref_q <= lfsr_in;
                        cnt_q <= '0;
                        if (sample_zero) begin
                            lockup_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_FAIL;
                        end else begin
                            state_q  <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (in_valid) begin
                        cnt_q <= cnt_inc;
                        // Priority: lockup, then recurrence, then timeout.
                        if (sample_zero) begin
                            lockup_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_FAIL;
                        end else if (lfsr_in == ref_q) begin
                            period_q  <= cnt_inc;
                            done_q    <= 1'b1;
                            maximal_q <= (cnt_inc == PERIOD_MAX);
                            busy_q    <= 1'b0;
                            state_q   <= S_DONE;
                        end else if (cnt_inc == TIMEOUT) begin
                            no_repeat_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_FAIL;
                        end
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign maximal   = maximal_q;
    assign period    = period_q;
    assign lockup    = lockup_q;
    assign no_repeat = no_repeat_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
module tb_lfsr_period_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        vld;
    logic [15:0] din;
    logic        busy, done, maximal, mismatch, lockup, no_repeat;
    logic [16:0] period, err_index;

    logic        start8;
    logic        vld8;
    logic [7:0]  din8;
    logic        busy8, done8, maximal8, mismatch8, lockup8, no_repeat8;
    logic [8:0]  period8, err_index8;

    int unsigned total;
    int unsigned bad;

    lfsr_period_checker #(.WIDTH(16), .TAPS(16'hB400)) u_dut (
        .clk(clk), .reset(rst), .start(start), .in_valid(vld), .lfsr_in(din),
        .busy(busy), .done(done), .maximal(maximal), .period(period),
        .mismatch(mismatch), .lockup(lockup), .no_repeat(no_repeat),
        .err_index(err_index)
    );

    lfsr_period_checker #(.WIDTH(8), .TAPS(8'hB8)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .in_valid(vld8), .lfsr_in(din8),
        .busy(busy8), .done(done8), .maximal(maximal8), .period(period8),
        .mismatch(mismatch8), .lockup(lockup8), .no_repeat(no_repeat8),
        .err_index(err_index8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        st;
        logic        v;
        logic [15:0] d;
        logic        e_busy;
        logic        e_done;
        logic        e_max;
        logic [16:0] e_per;
        logic        e_lock;
        logic        e_norep;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic s, input logic v,
                                input logic [15:0] d, input logic eb, input logic ed,
                                input logic em, input logic [16:0] ep,
                                input logic el, input logic en);
        vec_t x;
        x.rst_n = r; x.st = s; x.v = v; x.d = d;
        x.e_busy = eb; x.e_done = ed; x.e_max = em; x.e_per = ep;
        x.e_lock = el; x.e_norep = en;
        vt.push_back(x);
    endfunction

    initial begin
        logic [15:0] s;
        int unsigned n;
        total = 0;
        bad   = 0;

        //   rst st v  din      busy done max per lock norep
        // short cycle 3,5,9,3
        add(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0003, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0005, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0009, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0003, 0, 1, 0, 3, 0, 0);
        add(1, 0, 1, 16'h0005, 0, 1, 0, 3, 0, 0);
        // start with a sample in the same cycle: sample dropped
        add(1, 1, 1, 16'h0005, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        // lockup as reference
        add(1, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0007, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0009, 1, 0, 0, 0, 0, 0);
        // reset mid-COUNT while the reference value is presented
        add(0, 0, 1, 16'h0007, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0007, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0011, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0022, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0011, 0, 1, 0, 2, 0, 0);
        // start alone after DONE clears done
        add(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0040, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0040, 0, 1, 0, 1, 0, 0);
        // restart during COUNT discards the old reference
        add(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0001, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0002, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 16'h0001, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0005, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0001, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0005, 0, 1, 0, 2, 0, 0);
        // lockup during COUNT
        add(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0005, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 0);

        rst = 1'b0; start = 1'b0; vld = 1'b0; din = '0;
        start8 = 1'b0; vld8 = 1'b0; din8 = '0;
        tick();
        tick();
        chk("reset16", {busy, done, maximal, period, mismatch, lockup, no_repeat, err_index}, '0);
        chk("reset8", {busy8, done8, maximal8, period8, mismatch8, lockup8, no_repeat8, err_index8}, '0);
        rst = 1'b1;

        foreach (vt[i]) begin
            rst = vt[i].rst_n; start = vt[i].st; vld = vt[i].v; din = vt[i].d;
            tick();
            chk($sformatf("vec%0d", i),
                {busy, done, maximal, period, lockup, no_repeat},
                {vt[i].e_busy, vt[i].e_done, vt[i].e_max, vt[i].e_per,
                 vt[i].e_lock, vt[i].e_norep});
        end
        rst = 1'b1; start = 1'b0; vld = 1'b0;
        tick();

        // corrupt sample: 10th counted sample XOR 4
        start = 1'b1;
        tick();
        start = 1'b0;
        s = 16'hACE1;
        for (int k = 0; k < 16; k++) begin
            vld = 1'b1;
            din = (k == 10) ? (s ^ 16'h0004) : s;
            tick();
            s = nxt(s);
            if (k == 9) chk("corrupt_pre", {mismatch, err_index}, '0);
        end
        vld = 1'b0;
        tick();
`ifdef LFSR_CHK_PREDICT_EN
        chk("corrupt_flag", {busy, mismatch, err_index}, {1'b1, 1'b1, 17'd10});
`else
        chk("corrupt_flag", {busy, mismatch, err_index}, {1'b1, 1'b0, 17'd0});
`endif
        // measurement continues: return to the reference value
        vld = 1'b1; din = 16'hACE1;
        tick();
        vld = 1'b0;
        chk("corrupt_done", {busy, done, period}, {1'b0, 1'b1, 17'd16});

        // maximal run, continuous valid stream seeded with 0x0001
        s = 16'h0001;
        start = 1'b1; vld = 1'b1; din = s;
        tick();
        start = 1'b0;
        s = nxt(s);
        n = 0;
        while (n < 70000) begin
            din = s;
            tick();
            n++;
            s = nxt(s);
            if (done || !busy) break;
        end
        vld = 1'b0;
        chk("max_samples", 64'(n), 64'd65536);
        chk("max_result", {busy, done, maximal, period, mismatch, lockup, no_repeat},
            {1'b0, 1'b1, 1'b1, 17'd65535, 1'b0, 1'b0, 1'b0});

        // timeout on the 8-bit instance: ref 0x01 then constant 0x02
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        vld8 = 1'b1; din8 = 8'h01;
        tick();
        din8 = 8'h02;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 255) chk("timeout_pre", {busy8, done8, no_repeat8}, {1'b1, 1'b0, 1'b0});
        end
        vld8 = 1'b0;
        chk("timeout", {busy8, done8, lockup8, no_repeat8}, {1'b0, 1'b0, 1'b0, 1'b1});

        // a fresh start clears the sticky flag
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("timeout_clr", {busy8, no_repeat8}, {1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
